// File: rtl/domain_rst_pkg.sv
// Shared state encoding and counter-width helpers for the domain reset sequencer.
package domain_rst_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Phase counter spans 2^(n-1) cycles, the period of the slowest enable.
  function automatic int phase_width(input int n);
    return (n > 1) ? n - 1 : 1;
  endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the clock.
module reset_synchronizer (
  input  logic clock,
  input  logic reset_n,
  output logic rst_sync_n
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign rst_sync_n = sync_q;

endmodule

// File: rtl/domain_reset_sequencer.sv
// Divide-by-2^i clock enables plus per-domain resets released in order,
// each release aligned to its own domain's enable pulse.
module domain_reset_sequencer
  import domain_rst_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] domain_en,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   seq_done
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int SW = cnt_width(STAGGER);
  localparam int IW = cnt_width(NUM_DOMAINS - 1);
  localparam int PW = phase_width(NUM_DOMAINS);

  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAGGER_LOAD = SW'(STAGGER);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DOMAINS - 1);

  logic                   sync_n;
  state_e                 state_q,   state_d;
  logic [HW-1:0]          hold_q,    hold_d;
  logic [SW-1:0]          stagger_q, stagger_d;
  logic [IW-1:0]          idx_q,     idx_d;
  logic [PW-1:0]          phase_q,   phase_d;
  logic [NUM_DOMAINS-1:0] rst_q,     rst_d;
  logic                   done_q,    done_d;
  logic                   active;
  logic                   en_sel;

  reset_synchronizer u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .rst_sync_n (sync_n)
  );

  assign active = (state_q != ST_SYNC);

  // Domain i fires when the low i phase bits are all ones: once per 2^i cycles.
  generate
    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_en
      if (gi == 0) begin : g_base
        assign domain_en[gi] = active;
      end else begin : g_div
        assign domain_en[gi] = active & (&phase_q[gi-1:0]);
      end
    end
  endgenerate

  assign en_sel = domain_en[idx_q];

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stagger_d = stagger_q;
    idx_d     = idx_q;
    rst_d     = rst_q;
    done_d    = done_q;
    phase_d   = active ? phase_q + PW'(1) : phase_q;

    case (state_q)
      ST_SYNC: begin
        if (sync_n) begin
          state_d = ST_HOLD;
          hold_d  = '0;
          phase_d = '0;
        end
      end
      ST_HOLD: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_LAST) begin
          state_d   = ST_RELEASE;
          idx_d     = '0;
          stagger_d = '0;
        end
      end
      ST_RELEASE: begin
        if (stagger_q != '0) begin
          stagger_d = stagger_q - SW'(1);
        end else if (en_sel) begin
          rst_d[idx_q] = 1'b0;
          stagger_d    = STAGGER_LOAD;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    // Soft reset restarts from HOLD; the board-reset synchronizer is not re-run.
    if (sw_rst_req && active) begin
      state_d   = ST_HOLD;
      hold_d    = '0;
      phase_d   = '0;
      stagger_d = '0;
      idx_d     = '0;
      rst_d     = '1;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_SYNC;
      hold_q    <= '0;
      stagger_q <= '0;
      idx_q     <= '0;
      phase_q   <= '0;
      rst_q     <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      stagger_q <= stagger_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      rst_q     <= rst_d;
      done_q    <= done_d;
    end
  end

  assign domain_rst = rst_q;
  assign seq_done   = done_q;

endmodule

// File: tb/tb_domain_reset_sequencer.sv
// Directed bench: default-parameter sequencer plus a 1-domain, no-stagger variant.
module tb_domain_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       sw_b = 1'b0;
  logic [2:0] en_a, rst_a;
  logic       done_a;
  logic [0:0] en_b, rst_b;
  logic       done_b;

  int edge_no = 0;
  int errors  = 0;
  int checks  = 0;
  int pz;

  always #5 clock = ~clock;
  always @(posedge clock) edge_no <= edge_no + 1;

  domain_reset_sequencer #(.NUM_DOMAINS(3), .HOLD_CYCLES(4), .STAGGER(2)) u_dut_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .sw_rst_req (sw_rst_req),
    .domain_en  (en_a),
    .domain_rst (rst_a),
    .seq_done   (done_a)
  );

  domain_reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGGER(0)) u_dut_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .sw_rst_req (sw_b),
    .domain_en  (en_b),
    .domain_rst (rst_b),
    .seq_done   (done_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_no, obs, exp);
    end
  endtask

  // t = edges since the edge that entered HOLD with phase 0 (edge 3 after reset,
  // or the last edge sw_rst_req was sampled high).
  task automatic check_now(input int phase_zero, input bit with_b);
    int t;
    logic [2:0] er, ee;
    logic ed;
    t = edge_no - phase_zero;
    if (t < 0) begin
      er = 3'b111; ee = 3'b000; ed = 1'b0;
    end else begin
      er = {t < 12, t < 8, t < 5};
      ee = {(t % 4) == 3, (t % 2) == 1, 1'b1};
      ed = (t >= 12);
    end
    check_val("a_rst", 32'(rst_a), 32'(er));
    check_val("a_en", 32'(en_a), 32'(ee));
    check_val("a_done", 32'(done_a), 32'(ed));
    if (with_b) begin
      check_val("b_rst", 32'(rst_b), (t < 2) ? 32'd1 : 32'd0);
      check_val("b_en", 32'(en_b), (t < 0) ? 32'd0 : 32'd1);
      check_val("b_done", 32'(done_b), (t >= 2) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic step_check(input int n, input int phase_zero, input bit with_b);
    repeat (n) begin
      @(posedge clock);
      #1;
      check_now(phase_zero, with_b);
    end
  endtask

  task automatic sw_pulse(output int e);
    @(negedge clock);
    sw_rst_req = 1'b1;
    @(posedge clock);
    #1;
    sw_rst_req = 1'b0;
    e = edge_no;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_state_rst", 32'(rst_a), 32'h7);
    check_val("rst_state_en", 32'(en_a), 32'h0);
    check_val("rst_state_done", 32'(done_a), 32'h0);

    // Power-on sequence followed by a long DONE window for period checks.
    @(negedge clock);
    reset_n = 1'b1;
    pz = edge_no + 3;
    step_check(15 + 64, pz, 1'b1);

    // Soft reset pulse from DONE.
    sw_pulse(pz);
    check_now(pz, 1'b0);
    step_check(20, pz, 1'b0);

    // Board reset asserted mid-RELEASE, between edges 11 and 12.
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    @(negedge clock);
    reset_n = 1'b1;
    pz = edge_no + 3;
    step_check(11, pz, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("async_rst", 32'(rst_a), 32'h7);
    check_val("async_en", 32'(en_a), 32'h0);
    check_val("async_done", 32'(done_a), 32'h0);
    check_val("async_b_rst", 32'(rst_b), 32'h1);
    check_val("async_b_en", 32'(en_b), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    pz = edge_no + 3;
    step_check(20, pz, 1'b1);

    // Soft reset held for 10 edges, starting in RELEASE.
    sw_pulse(pz);
    step_check(6, pz, 1'b0);
    @(negedge clock);
    sw_rst_req = 1'b1;
    repeat (10) begin
      @(posedge clock);
      #1;
      check_val("held_rst", 32'(rst_a), 32'h7);
      check_val("held_done", 32'(done_a), 32'h0);
      check_val("held_en", 32'(en_a), 32'h1);
    end
    sw_rst_req = 1'b0;
    pz = edge_no;
    step_check(20, pz, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
